// File: rtl/pwm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_pkg : duty width and breathing-ramp state encoding shared by the PWM path
// Rev 1.0
// ----------------------------------------------------------------------------
package pwm_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HI   = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LO   = 3'd4
  } ramp_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_tick_gen : prescaler issuing a tick on the last count of each period
// Rev 1.0
// ----------------------------------------------------------------------------
module pwm_tick_gen #(
  parameter int unsigned PRESCALE = 262144
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned     CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  // Tick is qualified by hold so a paused period end is deferred, not dropped.
  assign tick_o = ~clr_i & ~hold_i & (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (!hold_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pwm_breath_ramp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_breath_ramp : triangle "breathing" duty sequencer feeding the PWM stage
// Rev 1.0
// ----------------------------------------------------------------------------
module pwm_breath_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 262144,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DUTY_MIN   = 0,
  parameter int unsigned DUTY_MAX   = 255,
  parameter int unsigned HOLD_TICKS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              pause_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_upd_o,
  output logic              cycle_done_o,
  output logic [2:0]        state_o
);

  localparam int                 W9        = DUTY_W + 1;
  localparam logic [DUTY_W-1:0]  MIN_V     = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0]  MAX_V     = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0]  STEP_V    = DUTY_W'(STEP);
  localparam logic [W9-1:0]      MAX_W9    = W9'(DUTY_MAX);
  localparam logic [W9-1:0]      DN_LIM    = W9'(DUTY_MIN + STEP);
  localparam int                 HW        = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_TICKS - 1);

  ramp_state_t       state_q;
  logic [DUTY_W-1:0] duty_q;
  logic [HW-1:0]     hold_q;
  logic              duty_upd_q;
  logic              cycle_done_q;

  logic              tick;
  logic [W9-1:0]     up_sum;
  logic              up_sat;
  logic              dn_sat;
  logic [DUTY_W-1:0] ramp_duty_d;

  pwm_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (~en_i | (state_q == IDLE)),
    .hold_i (pause_i),
    .tick_o (tick)
  );

  // Both saturation tests are done in 9 bits so the step can never wrap.
  assign up_sum = {1'b0, duty_q} + W9'(STEP);
  assign up_sat = (up_sum >= MAX_W9);
  assign dn_sat = ({1'b0, duty_q} < DN_LIM);

  always_comb begin
    ramp_duty_d = duty_q;
    case (state_q)
      RAMP_UP:   ramp_duty_d = up_sat ? MAX_V : up_sum[DUTY_W-1:0];
      RAMP_DOWN: ramp_duty_d = dn_sat ? MIN_V : duty_q - STEP_V;
      default:   ramp_duty_d = duty_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      hold_q       <= '0;
      duty_upd_q   <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      duty_upd_q   <= 1'b0;
      cycle_done_q <= 1'b0;
      if (!en_i) begin
        state_q <= IDLE;
        duty_q  <= '0;
        hold_q  <= '0;
      end else if (pause_i) begin
        state_q <= state_q;
      end else if (state_q == IDLE) begin
        state_q    <= RAMP_UP;
        duty_q     <= MIN_V;
        hold_q     <= '0;
        duty_upd_q <= (duty_q != MIN_V);
      end else if (tick) begin
        duty_q     <= ramp_duty_d;
        duty_upd_q <= (ramp_duty_d != duty_q);
        unique case (state_q)
          RAMP_UP: begin
            if (up_sat) begin
              hold_q  <= '0;
              state_q <= (HOLD_TICKS == 0) ? RAMP_DOWN : HOLD_HI;
            end
          end
          RAMP_DOWN: begin
            if (dn_sat) begin
              cycle_done_q <= 1'b1;
              hold_q       <= '0;
              state_q      <= (HOLD_TICKS == 0) ? RAMP_UP : HOLD_LO;
            end
          end
          HOLD_HI: begin
            hold_q <= hold_q + HW'(1);
            if (hold_q >= HOLD_LAST) state_q <= RAMP_DOWN;
          end
          HOLD_LO: begin
            hold_q <= hold_q + HW'(1);
            if (hold_q >= HOLD_LAST) state_q <= RAMP_UP;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign duty_o       = duty_q;
  assign duty_upd_o   = duty_upd_q;
  assign cycle_done_o = cycle_done_q;
  assign state_o      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_breath_ramp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pwm_breath_ramp : scoreboard bench, two configs (held triangle, hold-free clamp)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pwm_breath_ramp;
  import pwm_pkg::*;

  localparam int PRE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pause;
  logic [7:0] duty_a, duty_b;
  logic       upd_a, upd_b, done_a, done_b;
  logic [2:0] st_a, st_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_breath_ramp #(
    .PRESCALE(PRE), .STEP(64), .DUTY_MIN(0), .DUTY_MAX(255), .HOLD_TICKS(2)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pause_i(pause),
    .duty_o(duty_a), .duty_upd_o(upd_a), .cycle_done_o(done_a), .state_o(st_a)
  );

  pwm_breath_ramp #(
    .PRESCALE(PRE), .STEP(7), .DUTY_MIN(10), .DUTY_MAX(20), .HOLD_TICKS(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en), .pause_i(pause),
    .duty_o(duty_b), .duty_upd_o(upd_b), .cycle_done_o(done_b), .state_o(st_b)
  );

  typedef struct {
    int edge_n;
    int duty;
    bit done;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          m_step[2], m_min[2], m_max[2], m_hold_t[2];
  ramp_state_t m_st[2];
  int          m_duty[2], m_hc[2], m_pre[2];

  task automatic chk(input string tag, input logic [31:0] got, input int exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp_v, cyc);
    end
  endtask

  task automatic push(input int id, input int e, input int d, input bit dn);
    exp_t x;
    x.edge_n = e;
    x.duty   = d;
    x.done   = dn;
    if (id == 0) q_a.push_back(x);
    else         q_b.push_back(x);
  endtask

  task automatic model_reset(input int id);
    m_st[id]   = IDLE;
    m_duty[id] = 0;
    m_hc[id]   = 0;
    m_pre[id]  = 0;
  endtask

  // Reference behaviour for one clock edge e, pushing any duty change it causes.
  task automatic model_edge(input int id, input int e, input bit en_v, input bit pause_v);
    int nd;
    bit dn;
    nd = m_duty[id];
    dn = 1'b0;
    if (!en_v) begin
      model_reset(id);
    end else if (pause_v) begin
      nd = m_duty[id];
    end else if (m_st[id] == IDLE) begin
      m_st[id]  = RAMP_UP;
      m_pre[id] = 0;
      m_hc[id]  = 0;
      if (m_duty[id] != m_min[id]) push(id, e, m_min[id], 1'b0);
      m_duty[id] = m_min[id];
    end else begin
      m_pre[id]++;
      if (m_pre[id] == PRE) begin
        m_pre[id] = 0;
        case (m_st[id])
          RAMP_UP: begin
            if (m_duty[id] + m_step[id] >= m_max[id]) begin
              nd       = m_max[id];
              m_hc[id] = 0;
              m_st[id] = (m_hold_t[id] == 0) ? RAMP_DOWN : HOLD_HI;
            end else begin
              nd = m_duty[id] + m_step[id];
            end
          end
          RAMP_DOWN: begin
            if (m_duty[id] < m_min[id] + m_step[id]) begin
              nd       = m_min[id];
              dn       = 1'b1;
              m_hc[id] = 0;
              m_st[id] = (m_hold_t[id] == 0) ? RAMP_UP : HOLD_LO;
            end else begin
              nd = m_duty[id] - m_step[id];
            end
          end
          HOLD_HI: begin
            m_hc[id]++;
            if (m_hc[id] == m_hold_t[id]) m_st[id] = RAMP_DOWN;
          end
          HOLD_LO: begin
            m_hc[id]++;
            if (m_hc[id] == m_hold_t[id]) m_st[id] = RAMP_UP;
          end
          default: m_st[id] = IDLE;
        endcase
        if (nd != m_duty[id]) push(id, e, nd, dn);
        m_duty[id] = nd;
      end
    end
  endtask

  task automatic step(input bit en_v, input bit pause_v);
    en    = en_v;
    pause = pause_v;
    model_edge(0, cyc + 1, en_v, pause_v);
    model_edge(1, cyc + 1, en_v, pause_v);
    @(negedge clk);
  endtask

  task automatic mon(input int id, input logic upd, input logic dn, input logic [7:0] d);
    exp_t x;
    bit   due;
    due = 1'b0;
    if (id == 0) begin
      if (q_a.size() > 0) begin
        if (q_a[0].edge_n == cyc) begin
          x   = q_a.pop_front();
          due = 1'b1;
        end
      end
    end else begin
      if (q_b.size() > 0) begin
        if (q_b[0].edge_n == cyc) begin
          x   = q_b.pop_front();
          due = 1'b1;
        end
      end
    end
    if (due) begin
      chk(id == 0 ? "a_upd"  : "b_upd",  {31'b0, upd}, 1);
      chk(id == 0 ? "a_duty" : "b_duty", {24'b0, d},   x.duty);
      chk(id == 0 ? "a_done" : "b_done", {31'b0, dn},  int'(x.done));
    end else if (upd !== 1'b0 || dn !== 1'b0) begin
      chk(id == 0 ? "a_spurious_pulse" : "b_spurious_pulse", {30'b0, upd, dn}, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, upd_a, done_a, duty_a);
    mon(1, upd_b, done_b, duty_b);
  end

  initial begin
    m_step   = '{64, 7};
    m_min    = '{0, 10};
    m_max    = '{255, 20};
    m_hold_t = '{2, 0};
    model_reset(0);
    model_reset(1);

    rst_n = 1'b0;
    en    = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_duty_a",  {24'b0, duty_a}, 0);
    chk("rst_upd_a",   {31'b0, upd_a},  0);
    chk("rst_done_a",  {31'b0, done_a}, 0);
    chk("rst_state_a", {29'b0, st_a},   IDLE);
    chk("rst_duty_b",  {24'b0, duty_b}, 0);
    rst_n = 1'b1;

    // Full A period (48 cycles) plus the first update of the next one.
    repeat (60) step(1'b1, 1'b0);

    // Pause mid-ramp: the pending tick must be deferred by 5 cycles.
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    chk("pre_drop_duty_a", {24'b0, duty_a}, 192);

    step(1'b0, 1'b0);
    chk("drop_duty_a",  {24'b0, duty_a}, 0);
    chk("drop_state_a", {29'b0, st_a},   IDLE);
    chk("drop_upd_a",   {31'b0, upd_a},  0);
    chk("drop_duty_b",  {24'b0, duty_b}, 0);
    step(1'b0, 1'b0);

    repeat (20) step(1'b1, 1'b0);
    chk("hold_state_a", {29'b0, st_a},   HOLD_HI);
    chk("hold_duty_a",  {24'b0, duty_a}, 255);

    // Asynchronous reset well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_duty_a",  {24'b0, duty_a}, 0);
    chk("arst_state_a", {29'b0, st_a},   IDLE);
    chk("arst_upd_a",   {31'b0, upd_a},  0);
    chk("arst_done_a",  {31'b0, done_a}, 0);
    chk("arst_duty_b",  {24'b0, duty_b}, 0);
    chk("arst_state_b", {29'b0, st_b},   IDLE);
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (60) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    chk("a_queue_left", q_a.size(), 0);
    chk("b_queue_left", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
